// File: rtl/ps2_command_parser.sv
// Line editor and command parser between ps2_cleaner and display_controller.
// Collects printable keystrokes into a line buffer that is echoed live, and on
// Enter walks the line one character per cycle parsing "V<n>" / "A<n>" tokens.
// A valid line updates velocity/angle; a bad line leaves both untouched.
//
// Ports:
//   clock            system clock
//   reset            synchronous active-high reset
//   input_character  ASCII code, valid while input_made is high
//   input_made       one-cycle strobe per keystroke
//   line_content     buffer, character i in bits [8i+7:8i], unused slots 0
//   line_ready       one-cycle pulse when a line is committed
//   velocity         last accepted velocity (0..999), zero-extended
//   angle            last accepted angle (0..MAX_ANGLE), zero-extended
//   cmd_error        one-cycle pulse with line_ready when a line is rejected
//   overrun          one-cycle pulse when a keystroke arrives outside EDIT
module ps2_command_parser #(
    parameter int LINE_CHARS = 32,
    parameter int MAX_ANGLE  = 90
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [7:0]              input_character,
    input  logic                    input_made,
    output logic [8*LINE_CHARS-1:0] line_content,
    output logic                    line_ready,
    output logic [31:0]             velocity,
    output logic [31:0]             angle,
    output logic                    cmd_error,
    output logic                    overrun
);

    localparam int CW = $clog2(LINE_CHARS + 1);
    localparam int AW = $clog2(LINE_CHARS);
    localparam logic [CW-1:0] FULL  = CW'(LINE_CHARS);
    localparam logic [9:0]    MAX_A = 10'(MAX_ANGLE);

    typedef enum logic [1:0] {
        S_EDIT,
        S_PARSE,
        S_COMMIT,
        S_CLEAR
    } state_t;

    typedef enum logic [1:0] {
        T_NONE,
        T_VEL,
        T_ANG
    } tok_t;

    state_t      state_q, state_d;
    logic [7:0]  chars_q [LINE_CHARS];
    logic [7:0]  chars_d [LINE_CHARS];
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] idx_q, idx_d;

    // Token being scanned
    tok_t        tok_q, tok_d;
    logic [1:0]  ndig_q, ndig_d;
    logic [9:0]  acc_q, acc_d;

    // Line-level results gathered while scanning
    logic        err_q, err_d;
    logic        vnew_q, vnew_d;
    logic        anew_q, anew_d;
    logic [9:0]  vval_q, vval_d;
    logic [9:0]  aval_q, aval_d;

    // Published outputs
    logic [9:0]  vel_q, vel_d;
    logic [9:0]  ang_q, ang_d;
    logic        ready_q, ready_d;
    logic        cerr_q, cerr_d;
    logic        ovr_q, ovr_d;

    logic [7:0]  cur_ch;
    logic        is_space;
    logic        is_v;
    logic        is_a;
    logic        is_dig;
    logic        is_print;
    logic        tok_bad;
    logic        fin_err;

    assign cur_ch   = chars_q[AW'(idx_q)];
    assign is_space = (cur_ch == 8'h20);
    assign is_v     = (cur_ch == 8'h56) || (cur_ch == 8'h76);
    assign is_a     = (cur_ch == 8'h41) || (cur_ch == 8'h61);
    assign is_dig   = (cur_ch >= 8'h30) && (cur_ch <= 8'h39);
    assign is_print = (input_character >= 8'h20) &&
                      (input_character <= 8'h7E);

    // The token currently open would be rejected if it ended now
    assign tok_bad = (tok_q != T_NONE) &&
                     ((ndig_q == 2'd0) ||
                      ((tok_q == T_ANG) && (acc_q > MAX_A)));

    assign fin_err = err_q | tok_bad;

    always_comb begin
        state_d = state_q;
        chars_d = chars_q;
        count_d = count_q;
        idx_d   = idx_q;
        tok_d   = tok_q;
        ndig_d  = ndig_q;
        acc_d   = acc_q;
        err_d   = err_q;
        vnew_d  = vnew_q;
        anew_d  = anew_q;
        vval_d  = vval_q;
        aval_d  = aval_q;
        vel_d   = vel_q;
        ang_d   = ang_q;
        ready_d = 1'b0;
        cerr_d  = 1'b0;
        ovr_d   = input_made && (state_q != S_EDIT);

        unique case (state_q)
            S_EDIT: begin
                if (input_made) begin
                    if (is_print) begin
                        if (count_q != FULL) begin
                            chars_d[AW'(count_q)] = input_character;
                            count_d = count_q + 1'b1;
                        end
                    end else if (input_character == 8'h08) begin
                        if (count_q != '0) begin
                            chars_d[AW'(count_q - 1'b1)] = 8'h00;
                            count_d = count_q - 1'b1;
                        end
                    end else if ((input_character == 8'h0D) ||
                                 (input_character == 8'h0A)) begin
                        idx_d  = '0;
                        tok_d  = T_NONE;
                        ndig_d = 2'd0;
                        acc_d  = 10'd0;
                        err_d  = 1'b0;
                        vnew_d = 1'b0;
                        anew_d = 1'b0;
                        state_d = (count_q == '0) ? S_COMMIT : S_PARSE;
                    end
                end
            end

            S_PARSE: begin
                idx_d = idx_q + 1'b1;
                if (idx_d == count_q) begin
                    state_d = S_COMMIT;
                end
                if (is_space) begin
                    if (tok_bad) begin
                        err_d = 1'b1;
                    end else if (tok_q == T_VEL) begin
                        vnew_d = 1'b1;
                        vval_d = acc_q;
                    end else if (tok_q == T_ANG) begin
                        anew_d = 1'b1;
                        aval_d = acc_q;
                    end
                    tok_d  = T_NONE;
                    ndig_d = 2'd0;
                    acc_d  = 10'd0;
                end else if (is_v || is_a) begin
                    // A letter may only open a token, never continue one
                    if (tok_q != T_NONE) begin
                        err_d = 1'b1;
                    end else begin
                        tok_d  = is_v ? T_VEL : T_ANG;
                        ndig_d = 2'd0;
                        acc_d  = 10'd0;
                    end
                end else if (is_dig) begin
                    if ((tok_q == T_NONE) || (ndig_q == 2'd3)) begin
                        err_d = 1'b1;
                    end else begin
                        // acc <= 99 here, so 10 bits never overflow
                        acc_d  = acc_q * 10'd10 + {6'd0, cur_ch[3:0]};
                        ndig_d = ndig_q + 2'd1;
                    end
                end else begin
                    err_d = 1'b1;
                end
            end

            S_COMMIT: begin
                ready_d = 1'b1;
                cerr_d  = fin_err;
                if (!fin_err) begin
                    // The still-open token is the latest, so it wins
                    if (tok_q == T_VEL) begin
                        vel_d = acc_q;
                    end else if (vnew_q) begin
                        vel_d = vval_q;
                    end
                    if (tok_q == T_ANG) begin
                        ang_d = acc_q;
                    end else if (anew_q) begin
                        ang_d = aval_q;
                    end
                end
                state_d = S_CLEAR;
            end

            S_CLEAR: begin
                for (int i = 0; i < LINE_CHARS; i++) begin
                    chars_d[i] = 8'h00;
                end
                count_d = '0;
                state_d = S_EDIT;
            end

            default: begin
                state_d = S_EDIT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_EDIT;
            for (int i = 0; i < LINE_CHARS; i++) begin
                chars_q[i] <= 8'h00;
            end
            count_q <= '0;
            idx_q   <= '0;
            tok_q   <= T_NONE;
            ndig_q  <= 2'd0;
            acc_q   <= 10'd0;
            err_q   <= 1'b0;
            vnew_q  <= 1'b0;
            anew_q  <= 1'b0;
            vval_q  <= 10'd0;
            aval_q  <= 10'd0;
            vel_q   <= 10'd0;
            ang_q   <= 10'd0;
            ready_q <= 1'b0;
            cerr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            chars_q <= chars_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            tok_q   <= tok_d;
            ndig_q  <= ndig_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            vnew_q  <= vnew_d;
            anew_q  <= anew_d;
            vval_q  <= vval_d;
            aval_q  <= aval_d;
            vel_q   <= vel_d;
            ang_q   <= ang_d;
            ready_q <= ready_d;
            cerr_q  <= cerr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        line_content = '0;
        for (int i = 0; i < LINE_CHARS; i++) begin
            line_content[8*i +: 8] = chars_q[i];
        end
    end

    assign line_ready = ready_q;
    assign cmd_error  = cerr_q;
    assign overrun    = ovr_q;
    assign velocity   = {22'd0, vel_q};
    assign angle      = {22'd0, ang_q};

endmodule

// File: tb/tb_ps2_command_parser.sv
// Directed bench for ps2_command_parser: table of whole lines with expected
// results, plus hand-written sequences for editing, overflow and reset.
module tb_ps2_command_parser;

    logic         clock = 1'b0;
    logic         reset;
    logic [7:0]   input_character;
    logic         input_made;
    logic [255:0] line_content;
    logic         line_ready;
    logic [31:0]  velocity;
    logic [31:0]  angle;
    logic         cmd_error;
    logic         overrun;

    int n_vec = 0;
    int n_bad = 0;

    ps2_command_parser #(
        .LINE_CHARS(32),
        .MAX_ANGLE (90)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .input_character(input_character),
        .input_made     (input_made),
        .line_content   (line_content),
        .line_ready     (line_ready),
        .velocity       (velocity),
        .angle          (angle),
        .cmd_error      (cmd_error),
        .overrun        (overrun)
    );

    always #5 clock = ~clock;

    typedef struct {
        string txt;
        bit    err;
        int    vel;
        int    ang;
    } vec_t;

    vec_t vt[11];

    task automatic set_vec(input int i, input string t, input bit e,
                           input int v, input int a);
        vt[i].txt = t;
        vt[i].err = e;
        vt[i].vel = v;
        vt[i].ang = a;
    endtask

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] exp_line(input string s, input int n);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < n && i < 32; i++) begin
            r[8*i +: 8] = s[i];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic press(input logic [7:0] c);
        input_character = c;
        input_made = 1'b1;
        tick();
        input_made = 1'b0;
        input_character = 8'h00;
    endtask

    task automatic type_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            press(s[i]);
            chk({"echo ", s}, line_content, exp_line(s, i + 1));
        end
    endtask

    // Press Enter and follow the line through commit and clear.
    // inject: strobe a key during the first PARSE cycle.
    task automatic enter_check(input string name, input logic [255:0] txt,
                               input int n, input bit e, input int v,
                               input int a, input bit inject);
        int k;
        bit got;
        press(8'h0D);
        k = 0;
        got = 1'b0;
        if (inject) begin
            press(8'h5A);
            k = 1;
            chk({name, " overrun"}, 256'(overrun), 256'(1));
            chk({name, " not stored"}, line_content, txt);
            got = line_ready;
        end
        while (k < 40 && !got) begin
            tick();
            k++;
            got = line_ready;
        end
        chk({name, " ready seen"}, 256'(got), 256'(1));
        if (got) begin
            chk({name, " latency"}, 256'(k), 256'(n + 1));
            chk({name, " cmd_error"}, 256'(cmd_error), 256'(e));
            chk({name, " velocity"}, 256'(velocity), 256'(v));
            chk({name, " angle"}, 256'(angle), 256'(a));
            chk({name, " held text"}, line_content, txt);
            tick();
            chk({name, " ready pulse"}, 256'(line_ready), 256'(0));
            chk({name, " error pulse"}, 256'(cmd_error), 256'(0));
            chk({name, " cleared"}, line_content, 256'(0));
        end
    endtask

    initial begin
        logic [255:0] allb;
        bit seen;

        set_vec(0, "V120 A45", 0, 120, 45);
        set_vec(1, "A91", 1, 120, 45);
        set_vec(2, "a90", 0, 120, 90);
        set_vec(3, "V1234", 1, 120, 90);
        set_vec(4, "V", 1, 120, 90);
        set_vec(5, "  ", 0, 120, 90);
        set_vec(6, "  v7   a0 ", 0, 7, 0);
        set_vec(7, "A5 A6", 0, 7, 6);
        set_vec(8, "5", 1, 7, 6);
        set_vec(9, "V1 X", 1, 7, 6);
        set_vec(10, "V999 a1", 0, 999, 1);

        reset = 1'b1;
        input_made = 1'b0;
        input_character = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        chk("rst line", line_content, 256'(0));
        chk("rst vel", 256'(velocity), 256'(0));
        chk("rst ang", 256'(angle), 256'(0));
        chk("rst ready", 256'(line_ready), 256'(0));
        chk("rst err", 256'(cmd_error), 256'(0));
        chk("rst ovr", 256'(overrun), 256'(0));

        for (int i = 0; i < 11; i++) begin
            type_str(vt[i].txt);
            enter_check(vt[i].txt, exp_line(vt[i].txt, vt[i].txt.len()),
                        vt[i].txt.len(), vt[i].err, vt[i].vel,
                        vt[i].ang, 1'b0);
        end

        // Backspace editing
        type_str("V12X");
        press(8'h08);
        press(8'h08);
        chk("bs twice", line_content, exp_line("V1", 2));
        press(8'h33);
        chk("bs retype", line_content, exp_line("V13", 3));
        enter_check("V13", exp_line("V13", 3), 3, 0, 13, 1, 1'b0);

        // Backspace on empty buffer keeps count at 0
        press(8'h08);
        chk("bs empty", line_content, 256'(0));
        type_str("A2");
        enter_check("A2", exp_line("A2", 2), 2, 0, 13, 2, 1'b0);

        // 33 keys fill 32 slots; key during PARSE is an overrun
        allb = {32{8'h42}};
        for (int i = 0; i < 33; i++) begin
            press(8'h42);
        end
        chk("full buffer", line_content, allb);
        enter_check("full", allb, 32, 1, 13, 2, 1'b1);
        chk("ovr pulse end", 256'(overrun), 256'(0));

        // Reset mid-PARSE, with a simultaneous keystroke
        type_str("V500");
        press(8'h0D);
        tick();
        reset = 1'b1;
        input_made = 1'b1;
        input_character = 8'h51;
        tick();
        reset = 1'b0;
        input_made = 1'b0;
        input_character = 8'h00;
        chk("abort vel", 256'(velocity), 256'(0));
        chk("abort ang", 256'(angle), 256'(0));
        chk("abort line", line_content, 256'(0));
        chk("abort ready", 256'(line_ready), 256'(0));
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (line_ready || cmd_error || overrun) seen = 1'b1;
        end
        chk("abort quiet", 256'(seen), 256'(0));
        type_str("A3");
        enter_check("A3 post", exp_line("A3", 2), 2, 0, 0, 3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
